// File: rtl/sccb_cfg_seq.sv
// rtl/sccb_cfg_seq.sv - table-driven SCCB register-write sequencer
module sccb_cfg_seq #(
  parameter logic [7:0] DEV_ADDR   = 8'h78,
  parameter int         ADDR_W     = 16,
  parameter int         DEPTH      = 304,
  parameter int         IDX_W      = 9,
  parameter int         DELAY_UNIT = 100000,
  parameter int         MAX_RETRY  = 3,
  parameter int         AUTO_START = 1
) (
  input  logic                  clk_100,
  input  logic                  rst_100,
  input  logic                  start,
  output logic [IDX_W-1:0]      rom_addr,
  input  logic [ADDR_W+9:0]     rom_data,
  output logic                  i2c_req,
  output logic [ADDR_W+15:0]    i2c_data,
  input  logic                  i2c_ack,
  input  logic                  i2c_nack,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_idx
);

  // Width of the sub-tick cycle counter; at least one bit even for DELAY_UNIT=1.
  localparam int CNT_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_NOP   = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_REQ,
    S_WAIT_ACK,
    S_DELAY,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [3:0]            r_retry;
  logic [7:0]            r_ticks;
  logic [CNT_W-1:0]      r_cyc;
  logic                  r_auto_pend;
  logic                  r_req;
  logic [ADDR_W+15:0]    r_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [IDX_W-1:0]      r_err_idx;

  logic [1:0]            w_op;
  logic [ADDR_W-1:0]     w_reg_addr;
  logic [7:0]            w_reg_val;
  logic                  w_last;
  logic                  w_cyc_wrap;
  logic                  w_retry_ok;

  // ROM word fields; the ROM output is valid during DECODE.
  assign w_op       = rom_data[ADDR_W+9:ADDR_W+8];
  assign w_reg_addr = rom_data[ADDR_W+7:8];
  assign w_reg_val  = rom_data[7:0];

  assign w_last     = (r_idx == IDX_W'(DEPTH - 1));
  assign w_cyc_wrap = (r_cyc == CNT_W'(DELAY_UNIT - 1));
  assign w_retry_ok = (r_retry < 4'(MAX_RETRY));

  // The table index doubles as the ROM address, so it is stable across FETCH.
  assign rom_addr = r_idx;
  assign i2c_req  = r_req;
  assign i2c_data = r_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_idx  = r_err_idx;

  // Sequencer FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk_100 or negedge rst_100) begin
    if (!rst_100) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_retry     <= '0;
      r_ticks     <= '0;
      r_cyc       <= '0;
      r_auto_pend <= (AUTO_START != 0);
      r_req       <= 1'b0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_idx   <= '0;
    end else begin
      // The request is a single-cycle pulse; only entry into REQ raises it.
      r_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (start || r_auto_pend) begin
            r_auto_pend <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_FETCH;
          end
        end

        S_FETCH: begin
          r_state <= S_DECODE;
        end

        S_DECODE: begin
          r_retry <= '0;
          case (w_op)
            OP_WRITE: begin
              r_data  <= {DEV_ADDR, w_reg_addr, w_reg_val};
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
            OP_DELAY: begin
              r_ticks <= w_reg_val;
              r_cyc   <= '0;
              r_state <= S_DELAY;
            end
            OP_NOP: begin
              if (w_last) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_state <= S_FETCH;
              end
            end
            default: begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          endcase
        end

        S_REQ: begin
          r_state <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (i2c_ack) begin
            if (!i2c_nack) begin
              if (w_last) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_state <= S_FETCH;
              end
            end else if (w_retry_ok) begin
              r_retry <= r_retry + 1'b1;
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end else begin
              r_err_idx <= r_idx;
              r_error   <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_ERR;
            end
          end
        end

        S_DELAY: begin
          // A zero tick count is checked first, so the exit costs one extra cycle.
          if (r_ticks == 8'd0) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_FETCH;
            end
          end else if (w_cyc_wrap) begin
            r_cyc   <= '0;
            r_ticks <= r_ticks - 1'b1;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end

        S_DONE, S_ERR: begin
          if (start) begin
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_err_idx <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_FETCH;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// tb/tb_sccb_cfg_seq.sv - directed bench for sccb_cfg_seq
module tb_sccb_cfg_seq;

  logic        clk_100;
  logic        rst_100;
  logic        start;
  logic [1:0]  rom_addr;
  logic [25:0] rom_data;
  logic        i2c_req;
  logic [31:0] i2c_data;
  logic        i2c_ack;
  logic        i2c_nack;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_idx;

  sccb_cfg_seq #(
    .DEV_ADDR   (8'h78),
    .ADDR_W     (16),
    .DEPTH      (4),
    .IDX_W      (2),
    .DELAY_UNIT (10),
    .MAX_RETRY  (3),
    .AUTO_START (1)
  ) u_dut (
    .clk_100  (clk_100),
    .rst_100  (rst_100),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .i2c_req  (i2c_req),
    .i2c_data (i2c_data),
    .i2c_ack  (i2c_ack),
    .i2c_nack (i2c_nack),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_idx  (err_idx)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  // Synchronous ROM: data one cycle after the address.
  logic [25:0] rom [4];
  always @(posedge clk_100) rom_data <= rom[rom_addr];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [25:0] e_wr(input logic [15:0] a, input logic [7:0] v);
    return {2'b00, a, v};
  endfunction
  function automatic logic [25:0] e_op(input logic [1:0] op, input logic [7:0] v);
    return {op, 16'h0000, v};
  endfunction

  // Engine model and monitor, active on the falling edge.
  int          cyc = 0, n_req = 0, n_ack = 0, max_addr = 0, lat_cnt = 0;
  int          ack_cyc0 = -1, req_cyc1 = -1;
  int          nack_left [4];
  logic [31:0] first_data = '0, last_data = '0;
  bit          b2b = 1'b0, prev_req = 1'b0;
  logic        stat_clr = 1'b0;

  initial begin
    i2c_ack = 1'b0;
    i2c_nack = 1'b0;
    for (int i = 0; i < 4; i++) nack_left[i] = 0;
    forever begin
      @(negedge clk_100);
      cyc++;
      i2c_ack = 1'b0;
      i2c_nack = 1'b0;
      if (stat_clr) begin
        n_req = 0; n_ack = 0; max_addr = 0; b2b = 1'b0;
        ack_cyc0 = -1; req_cyc1 = -1;
      end else if (int'(rom_addr) > max_addr) begin
        max_addr = int'(rom_addr);
      end
      if (i2c_req && prev_req) b2b = 1'b1;
      prev_req = i2c_req;
      if (!rst_100) begin
        lat_cnt = 0;
      end else if (i2c_req) begin
        if (n_req == 0) first_data = i2c_data;
        if (n_req == 1) req_cyc1 = cyc;
        last_data = i2c_data;
        n_req++;
        lat_cnt = 2;
      end else if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          i2c_ack = 1'b1;
          if (nack_left[rom_addr] > 0) begin
            i2c_nack = 1'b1;
            nack_left[rom_addr]--;
          end
          if (n_ack == 0) ack_cyc0 = cyc;
          n_ack++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_100);
    #1;
  endtask

  task automatic start_run();
    stat_clr = 1'b1;
    start = 1'b1;
    tick();
    stat_clr = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!(done || error) && k < 600) begin
      tick();
      k++;
    end
    chk_eq(tag, 32'(done | error), 32'd1);
  endtask

  task automatic wait_req(input string tag, input int n);
    int k = 0;
    while (n_req < n && k < 200) begin
      tick();
      k++;
    end
    chk_eq(tag, 32'(n_req >= n), 32'd1);
  endtask

  task automatic load_writes();
    rom[0] = e_wr(16'h3103, 8'h11);
    rom[1] = e_wr(16'h3008, 8'h82);
    rom[2] = e_wr(16'h3017, 8'hFF);
    rom[3] = e_wr(16'h3018, 8'h7F);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk_eq({tag, "_req"},      32'(i2c_req),  32'd0);
    chk_eq({tag, "_data"},     i2c_data,      32'd0);
    chk_eq({tag, "_busy"},     32'(busy),     32'd0);
    chk_eq({tag, "_done"},     32'(done),     32'd0);
    chk_eq({tag, "_error"},    32'(error),    32'd0);
    chk_eq({tag, "_err_idx"},  32'(err_idx),  32'd0);
  endtask

  initial begin
    rst_100 = 1'b0;
    start = 1'b0;
    load_writes();
    repeat (3) tick();
    chk_reset_vals("rst");

    // Four writes, auto-started after reset release.
    rst_100 = 1'b1;
    wait_end("s1_end");
    chk_eq("s1_nreq", 32'(n_req), 32'd4);
    chk_eq("s1_first_data", first_data, 32'h7831_0311);
    chk_eq("s1_last_data", last_data, 32'h7830_187F);
    chk_eq("s1_done", 32'(done), 32'd1);
    chk_eq("s1_error", 32'(error), 32'd0);
    chk_eq("s1_busy", 32'(busy), 32'd0);
    chk_eq("s1_rom_addr", 32'(rom_addr), 32'd3);

    // DELAY 3 ticks of 10 cycles: ack0 -> next req = 30 + 6 cycles.
    rom[1] = e_op(2'b01, 8'd3);
    rom[3] = e_op(2'b11, 8'd0);
    start_run();
    chk_eq("s2_done_clr", 32'(done), 32'd0);
    chk_eq("s2_busy", 32'(busy), 32'd1);
    wait_end("s2_end");
    chk_eq("s2_nreq", 32'(n_req), 32'd2);
    chk_eq("s2_gap", 32'(req_cyc1 - ack_cyc0), 32'd36);
    chk_eq("s2_last_data", last_data, 32'h7830_17FF);

    // DELAY 0 adds no ticks.
    rom[1] = e_op(2'b01, 8'd0);
    start_run();
    wait_end("s2z_end");
    chk_eq("s2z_gap", 32'(req_cyc1 - ack_cyc0), 32'd6);

    // Three NACKs on entry 2, then ACK.
    load_writes();
    nack_left[2] = 3;
    start_run();
    wait_end("s3_end");
    chk_eq("s3_nreq", 32'(n_req), 32'd7);
    chk_eq("s3_done", 32'(done), 32'd1);
    chk_eq("s3_error", 32'(error), 32'd0);
    chk_eq("s3_b2b", 32'(b2b), 32'd0);

    // Four NACKs on entry 2: retries exhausted.
    nack_left[2] = 4;
    start_run();
    wait_end("s4_end");
    repeat (20) tick();
    chk_eq("s4_nreq", 32'(n_req), 32'd6);
    chk_eq("s4_error", 32'(error), 32'd1);
    chk_eq("s4_done", 32'(done), 32'd0);
    chk_eq("s4_err_idx", 32'(err_idx), 32'd2);
    chk_eq("s4_busy", 32'(busy), 32'd0);

    // start from ERR clears status and replays from index 0.
    nack_left[2] = 0;
    start_run();
    chk_eq("s5_error_clr", 32'(error), 32'd0);
    chk_eq("s5_err_idx_clr", 32'(err_idx), 32'd0);
    wait_end("s5_end");
    chk_eq("s5_nreq", 32'(n_req), 32'd4);
    chk_eq("s5_done", 32'(done), 32'd1);
    chk_eq("s5_first_data", first_data, 32'h7831_0311);

    // END at entry 1.
    rom[1] = e_op(2'b11, 8'd0);
    start_run();
    wait_end("s6_end");
    chk_eq("s6_nreq", 32'(n_req), 32'd1);
    chk_eq("s6_max_addr", 32'(max_addr), 32'd1);
    chk_eq("s6_done", 32'(done), 32'd1);

    // NOP at entry 1 issues no request.
    rom[1] = e_op(2'b10, 8'd0);
    start_run();
    wait_end("s6n_end");
    chk_eq("s6n_nreq", 32'(n_req), 32'd3);
    chk_eq("s6n_last_data", last_data, 32'h7830_187F);

    // start while busy is ignored.
    load_writes();
    start_run();
    wait_req("s7_req", 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end("s7_end");
    chk_eq("s7_nreq", 32'(n_req), 32'd4);

    // Reset during WAIT_ACK, then automatic rerun.
    start_run();
    wait_req("s8_req", 1);
    tick();
    chk_eq("s8_busy_pre", 32'(busy), 32'd1);
    rst_100 = 1'b0;
    #1;
    chk_reset_vals("s8");
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    rst_100 = 1'b1;
    wait_end("s8_end");
    chk_eq("s8_nreq", 32'(n_req), 32'd4);
    chk_eq("s8_done", 32'(done), 32'd1);

    // Reset during DELAY, then automatic rerun.
    rom[1] = e_op(2'b01, 8'd3);
    rom[3] = e_op(2'b11, 8'd0);
    start_run();
    begin
      int k = 0;
      while (n_ack < 1 && k < 200) begin
        tick();
        k++;
      end
    end
    repeat (12) tick();
    chk_eq("s9_busy_pre", 32'(busy), 32'd1);
    chk_eq("s9_rom_addr_pre", 32'(rom_addr), 32'd1);
    rst_100 = 1'b0;
    #1;
    chk_reset_vals("s9");
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    rst_100 = 1'b1;
    wait_end("s9_end");
    chk_eq("s9_nreq", 32'(n_req), 32'd2);
    chk_eq("s9_gap", 32'(req_cyc1 - ack_cyc0), 32'd36);
    chk_eq("s9_b2b", 32'(b2b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sccb_cfg_seq.md
# sccb_cfg_seq

Table-driven SCCB/I2C register-write sequencer for the camera front end: next generation of the sensor configuration FSM. Walks a parametrised-depth external command ROM and issues register writes through the existing `send_i2c` req/ack engine. Adds 8/16-bit register addressing, in-table millisecond delays, early end markers, bounded NACK retry, restart on demand and done/error status. Sits between the clk_100 system domain and the sensor's SCCB pins.

## Interface
- `DEV_ADDR`, 8'h78: 8-bit SCCB write address placed in the top byte of every transfer.
- `ADDR_W`, 16: register address width; legal values are 8 and 16.
- `DEPTH`, 304: number of ROM entries; 1..2^IDX_W.
- `IDX_W`, 9: ROM index width.
- `DELAY_UNIT`, 100000: clk_100 cycles per delay tick (1 ms at 100 MHz).
- `MAX_RETRY`, 3: extra attempts after a NACK before error; range 0..15.
- `AUTO_START`, 1: 1 starts the sequence once after reset without a `start` pulse.

Ports:
- `clk_100`, in, 1: single clock, all logic on the rising edge.
- `rst_100`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse that (re)runs the table from index 0.
- `rom_addr`, out, IDX_W: ROM index. The ROM is synchronous, with data valid one cycle after the address.
- `rom_data`, in, 2+ADDR_W+8: {op[1:0], reg_addr, reg_val}.
- `i2c_req`, out, 1: one-cycle request pulse to the engine.
- `i2c_data`, out, 8+ADDR_W+8: {DEV_ADDR, reg_addr, reg_val}.
- `i2c_ack`, in, 1: one-cycle pulse from the engine when the transfer finishes.
- `i2c_nack`, in, 1: qualified by `i2c_ack`; 1 means the slave did not acknowledge.
- `busy`, out, 1: high in any state other than IDLE, DONE and ERR.
- `done`, out, 1: level; table completed.
- `error`, out, 1: level; retries exhausted.
- `err_idx`, out, IDX_W: index of the failing entry. Valid while `error` is high.

## Operation
Opcodes:
- 00 WRITE: write `reg_val` to `reg_addr`.
- 01 DELAY: wait `reg_val` × DELAY_UNIT cycles.
- 10 NOP: skip the entry.
- 11 END: finish early.

States: IDLE, FETCH, DECODE, REQ, WAIT_ACK, DELAY, DONE, ERR.
- IDLE: `idx`=0. Goes to FETCH on `start`, or one cycle after reset release when AUTO_START=1.
- FETCH: drive `rom_addr`=`idx`, then go to DECODE.
- DECODE: latch `rom_data` and clear `retry`. Dispatch on op:
  - WRITE goes to REQ.
  - DELAY goes to DELAY with tick count = `reg_val`.
  - NOP goes to ADVANCE.
  - END goes to DONE.
- REQ: `i2c_req`=1 for this cycle only. `i2c_data` is loaded here and held until the next DECODE. Next state is WAIT_ACK.
- WAIT_ACK: on `i2c_ack` with !`i2c_nack`, go to ADVANCE. On `i2c_ack` with `i2c_nack`:
  - if `retry` < MAX_RETRY: `retry`+1, back to REQ.
  - otherwise: `err_idx`=`idx`, go to ERR.
- DELAY: a cycle counter runs 0..DELAY_UNIT-1. Each wrap decrements the tick count; go to ADVANCE when the count reaches 0. `reg_val`=0 goes to ADVANCE on the next cycle.
- ADVANCE is a transition action, not a state: if `idx`==DEPTH-1 go to DONE; otherwise `idx`+1 and go to FETCH.
- DONE and ERR hold their status. `start` clears `done`, `error` and `err_idx`, sets `idx`=0 and goes to FETCH.
- `start` in any busy state is ignored. `i2c_ack` outside WAIT_ACK is ignored.
- When ADDR_W=8 the engine is the 3-byte variant. Field packing is unchanged.

## Timing
- Reset values: `rom_addr`=0, `i2c_req`=0, `i2c_data`=0, `busy`=0, `done`=0, `error`=0, `err_idx`=0. All counters are 0.
- Reset mid-transfer drops `i2c_req` and `busy` immediately; the engine is reset by the same `rst_100`.
- WRITE entry overhead: FETCH, DECODE, REQ = 3 cycles before the engine runs. 1 cycle after `i2c_ack` the next FETCH starts.
- `i2c_req` is never high on consecutive cycles. Each retry inserts at least one WAIT_ACK cycle.
- DELAY of N ticks occupies exactly N×DELAY_UNIT cycles in DELAY, plus 1 ADVANCE cycle.
- `done` and `error` rise the cycle after the terminal event and are mutually exclusive.

## Test plan
- DEPTH=4 ROM of 4 WRITEs, all acked, AUTO_START=1:
  - four `i2c_req` pulses; the first `i2c_data`=32'h78_3103_11;
  - `done`=1 after the 4th ack, `busy`=0, `rom_addr`=3.
- Entry 1 is DELAY 3 with DELAY_UNIT=10: the gap between ack 0 and the next `i2c_req` is 30 + fixed overhead cycles, measured exactly. DELAY 0 adds no ticks.
- NACK on entry 2 with MAX_RETRY=3:
  - nacked 3 times then acked: 4 requests, sequence completes with `done`.
  - nacked 4 times: `error`=1, `err_idx`=2, no further `i2c_req`.
- END at entry 1 of 4: `done` after 1 write, `rom_addr` never reaches 2. A NOP entry produces no request.
- `start` pulsed while busy is ignored. `start` in ERR clears `error` and replays from index 0.
- `rst_100` low asserted during WAIT_ACK and during DELAY: all outputs take reset values asynchronously, and the sequence reruns cleanly after release.
